// File: rtl/act_pkg.sv
// Shared types and constants for the activation sign-compare arbiter.
package act_pkg;

  localparam int unsigned LANE_SIG    = 0;
  localparam int unsigned LANE_TANH   = 1;
  localparam int unsigned NLANE       = 2;
  localparam int unsigned XDW_DEFAULT = 16;

  // Lane tag carried alongside an operand through the comparator latency
  typedef struct packed {
    logic vld;
    logic lane;
  } lane_tag_t;

  localparam lane_tag_t TAG_IDLE = '{vld: 1'b0, lane: 1'b0};

endpackage

// File: rtl/act_cmp_arbiter_if.sv
// Lane request/response and shared-comparator signals for act_cmp_arbiter.
interface act_cmp_arbiter_if
  import act_pkg::*;
#(
  parameter int unsigned xDW = XDW_DEFAULT
) ();

  logic [NLANE-1:0]     req_valid;
  logic [NLANE*xDW-1:0] req_x;
  logic [NLANE-1:0]     req_ready;
  logic                 hold;
  logic                 cmp_en;
  logic [xDW-1:0]       cmp_x;
  logic                 cmp_out;
  logic                 cmp_valid;
  logic [NLANE-1:0]     rsp_valid;
  logic                 rsp_ge;
  logic                 err;

  // Lane front ends and comparator side
  modport master (
    output req_valid, req_x, hold, cmp_out, cmp_valid,
    input  req_ready, cmp_en, cmp_x, rsp_valid, rsp_ge, err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_x, hold, cmp_out, cmp_valid,
    output req_ready, cmp_en, cmp_x, rsp_valid, rsp_ge, err
  );

endinterface

// File: rtl/act_tag_pipe.sv
// Shift register of lane tags matching the shared comparator latency (CMP_LAT+1 stages).
module act_tag_pipe
  import act_pkg::*;
#(
  parameter int unsigned CMP_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  lane_tag_t tag_in,
  output lane_tag_t tag_tail
);

  localparam int unsigned NSTG = CMP_LAT + 1;

  lane_tag_t [NSTG-1:0] stg;

  // Free-running: the comparator cannot stall, so neither does the tag pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= {NSTG{TAG_IDLE}};
    end else begin
      stg <= {stg[NSTG-2:0], tag_in};
    end
  end

  assign tag_tail = stg[NSTG-1];

endmodule

// File: rtl/act_cmp_arbiter.sv
// Round-robin share of one sign comparator between sigmoid and tanh lanes.
// Optional grant counters enabled by defining ACT_CMP_ARB_STATS_EN.
module act_cmp_arbiter
  import act_pkg::*;
#(
  parameter int unsigned xDW     = XDW_DEFAULT,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  act_cmp_arbiter_if.slave   bus
`ifdef ACT_CMP_ARB_STATS_EN
  ,
  output logic [31:0]        gnt_cnt0,
  output logic [31:0]        gnt_cnt1
`endif
);

  logic [NLANE-1:0] gnt;
  logic             xfer;
  logic             rr_ptr;
  logic [xDW-1:0]   x_sel;
  logic             cmp_en_q;
  logic [xDW-1:0]   cmp_x_q;
  logic [NLANE-1:0] rsp_valid_q;
  logic             rsp_ge_q;
  logic             err_q;
  lane_tag_t        tag_in;
  lane_tag_t        tag_tail;

  // Grant: hold blocks everything, a lone request wins, a tie goes to rr_ptr
  always_comb begin
    gnt = '0;
    if (!bus.hold) begin
      if (bus.req_valid == 2'b11) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = bus.req_valid;
      end
    end
  end

  assign xfer   = |gnt;
  assign x_sel  = gnt[1] ? bus.req_x[2*xDW-1:xDW] : bus.req_x[xDW-1:0];
  assign tag_in = '{vld: xfer, lane: gnt[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      cmp_en_q <= 1'b0;
      cmp_x_q  <= '0;
    end else begin
      cmp_en_q <= xfer;
      if (xfer) begin
        rr_ptr  <= ~gnt[1];
        cmp_x_q <= x_sel;
      end
    end
  end

  act_tag_pipe #(
    .CMP_LAT (CMP_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_in   (tag_in),
    .tag_tail (tag_tail)
  );

  // Responses are steered by the tag pipe; cmp_valid is only cross-checked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_ge_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= tag_tail.vld ? (tag_tail.lane ? 2'b10 : 2'b01) : 2'b00;
      if (tag_tail.vld) begin
        rsp_ge_q <= bus.cmp_out;
      end
      if (tag_tail.vld != bus.cmp_valid) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.cmp_en    = cmp_en_q;
  assign bus.cmp_x     = cmp_x_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ge    = rsp_ge_q;
  assign bus.err       = err_q;

`ifdef ACT_CMP_ARB_STATS_EN
  localparam int unsigned CNT_W = 32;

  // Saturating per-lane transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt[LANE_SIG] && (gnt_cnt0 != '1)) begin
        gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      end
      if (gnt[LANE_TANH] && (gnt_cnt1 != '1)) begin
        gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
    end
  end
`endif

endmodule
